// File: rtl/f2_anchor_lock_tracker_if.sv
// f2_anchor_lock_tracker_if
//   Bundles the sample-rate inputs and the lock-tracking outputs of
//   f2_anchor_lock_tracker.
//   master : drives clk_en, f2_alignment, f2_detuning, episodes_clr and
//            observes the tracker outputs (upstream/host side)
//   slave  : the tracker itself
//   Signals:
//     clk_en        sample strobe
//     f2_alignment  signed Q14 alignment from the boundary detector
//     f2_detuning   signed |f2 - SR3| detuning, OMEGA_DT units
//     episodes_clr  synchronous clear of lock_episodes
//     lock_state    0=IDLE 1=ARMING 2=LOCKED 3=RELEASING
//     locked        high in LOCKED or RELEASING
//     lock_onset    one-cycle pulse on entry to LOCKED
//     lock_release  one-cycle pulse on return to IDLE from a lock episode
//     dwell_count   samples spent in the current episode
//     last_dwell    length of the last completed episode
//     lock_episodes completed-episode count
//     align_smooth  EMA of the clamped alignment, Q14
interface f2_anchor_lock_tracker_if #(
    parameter int WIDTH = 18,
    parameter int CNT_W = 16
);
    logic                    clk_en;
    logic signed [WIDTH-1:0] f2_alignment;
    logic signed [WIDTH-1:0] f2_detuning;
    logic                    episodes_clr;
    logic [1:0]              lock_state;
    logic                    locked;
    logic                    lock_onset;
    logic                    lock_release;
    logic [CNT_W-1:0]        dwell_count;
    logic [CNT_W-1:0]        last_dwell;
    logic [CNT_W-1:0]        lock_episodes;
    logic signed [WIDTH-1:0] align_smooth;

    modport master (
        output clk_en, f2_alignment, f2_detuning, episodes_clr,
        input  lock_state, locked, lock_onset, lock_release,
               dwell_count, last_dwell, lock_episodes, align_smooth
    );

    modport slave (
        input  clk_en, f2_alignment, f2_detuning, episodes_clr,
        output lock_state, locked, lock_onset, lock_release,
               dwell_count, last_dwell, lock_episodes, align_smooth
    );
endinterface

// File: rtl/f2_anchor_lock_tracker.sv
// f2_anchor_lock_tracker
//   Consumes the f2 boundary detector's Q14 alignment and detuning and runs a
//   hysteretic IDLE/ARMING/LOCKED/RELEASING state machine that declares
//   f2-SR3 stability-anchor lock episodes. Tracks dwell of the current
//   episode, the length of the last completed episode, a completed-episode
//   count, and an exponential moving average of the clamped alignment.
//   Ports:
//     clk  : clock
//     rst  : asynchronous active-high reset
//     bus  : f2_anchor_lock_tracker_if.slave (inputs/outputs listed there)
module f2_anchor_lock_tracker #(
    parameter int WIDTH      = 18,
    parameter int ENTER_TH   = 12288,
    parameter int EXIT_TH    = 8192,
    parameter int ENTER_HOLD = 8,
    parameter int EXIT_HOLD  = 4,
    parameter int MAX_DET    = 16,
    parameter int CNT_W      = 16,
    parameter int EMA_SHIFT  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    f2_anchor_lock_tracker_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        LOCKED    = 2'd2,
        RELEASING = 2'd3
    } state_t;

    localparam int HOLD_MAX = (ENTER_HOLD > EXIT_HOLD) ? ENTER_HOLD : EXIT_HOLD;
    localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;

    localparam logic signed [WIDTH-1:0] ONE_Q14    = WIDTH'(16384);
    localparam logic signed [WIDTH-1:0] ENTER_TH_S = WIDTH'(ENTER_TH);
    localparam logic signed [WIDTH-1:0] EXIT_TH_S  = WIDTH'(EXIT_TH);
    localparam logic signed [WIDTH-1:0] MAX_DET_S  = WIDTH'(MAX_DET);
    localparam logic [HOLD_W-1:0]       ENTER_LAST = HOLD_W'(ENTER_HOLD - 1);
    localparam logic [HOLD_W-1:0]       EXIT_LAST  = HOLD_W'(EXIT_HOLD - 1);
    localparam logic [HOLD_W-1:0]       HOLD_ONE   = HOLD_W'(1);
    localparam logic [CNT_W-1:0]        CNT_MAX    = '1;

    state_t                  state_q, state_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [CNT_W-1:0]        dwell_q, dwell_d;
    logic [CNT_W-1:0]        last_dwell_q, last_dwell_d;
    logic [CNT_W-1:0]        episodes_q, episodes_d;
    logic signed [WIDTH-1:0] smooth_q, smooth_d;
    logic                    onset_q, onset_d;
    logic                    release_q, release_d;

    logic signed [WIDTH-1:0] align_clamped;
    logic                    veto;
    logic [CNT_W-1:0]        dwell_inc;
    logic [CNT_W-1:0]        episodes_inc;
    logic signed [WIDTH:0]   ema_diff;
    logic signed [WIDTH:0]   ema_step;
    logic                    do_release;

    // Input conditioning shared by the FSM and the EMA.
    always_comb begin
        if (bus.f2_alignment[WIDTH-1]) begin
            align_clamped = '0;
        end else if (bus.f2_alignment > ONE_Q14) begin
            align_clamped = ONE_Q14;
        end else begin
            align_clamped = bus.f2_alignment;
        end
        veto         = bus.f2_detuning > MAX_DET_S;
        dwell_inc    = (dwell_q == CNT_MAX) ? dwell_q : dwell_q + 1'b1;
        episodes_inc = (episodes_q == CNT_MAX) ? episodes_q : episodes_q + 1'b1;
        // One extra bit keeps the difference exact across the full [0,1] range.
        ema_diff     = {align_clamped[WIDTH-1], align_clamped} - {smooth_q[WIDTH-1], smooth_q};
        ema_step     = ema_diff >>> EMA_SHIFT;
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        dwell_d      = dwell_q;
        last_dwell_d = last_dwell_q;
        episodes_d   = episodes_q;
        smooth_d     = smooth_q;
        onset_d      = 1'b0;  // pulses self-clear on every clk edge
        release_d    = 1'b0;
        do_release   = 1'b0;

        if (bus.clk_en) begin
            smooth_d = smooth_q + ema_step[WIDTH-1:0];
            case (state_q)
                IDLE: begin
                    if (!veto && align_clamped >= ENTER_TH_S) begin
                        state_d = ARMING;
                        hold_d  = HOLD_ONE;
                    end
                end
                ARMING: begin
                    if (veto || align_clamped < ENTER_TH_S) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end else if (hold_q == ENTER_LAST) begin
                        state_d = LOCKED;
                        hold_d  = '0;
                        dwell_d = '0;
                        onset_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                LOCKED: begin
                    dwell_d = dwell_inc;
                    if (veto) begin
                        do_release = 1'b1;
                    end else if (align_clamped < EXIT_TH_S) begin
                        state_d = RELEASING;
                        hold_d  = HOLD_ONE;
                    end
                end
                RELEASING: begin
                    dwell_d = dwell_inc;
                    if (veto) begin
                        do_release = 1'b1;
                    end else if (align_clamped >= EXIT_TH_S) begin
                        state_d = LOCKED;
                        hold_d  = '0;
                    end else if (hold_q == EXIT_LAST) begin
                        do_release = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Normal and veto-abort releases close the episode identically;
            // the releasing sample itself counts toward the episode length.
            if (do_release) begin
                state_d      = IDLE;
                hold_d       = '0;
                dwell_d      = '0;
                last_dwell_d = dwell_inc;
                episodes_d   = episodes_inc;
                release_d    = 1'b1;
            end
        end

        // Clear wins over a same-cycle increment and ignores clk_en.
        if (bus.episodes_clr) begin
            episodes_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            dwell_q      <= '0;
            last_dwell_q <= '0;
            episodes_q   <= '0;
            smooth_q     <= '0;
            onset_q      <= 1'b0;
            release_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            dwell_q      <= dwell_d;
            last_dwell_q <= last_dwell_d;
            episodes_q   <= episodes_d;
            smooth_q     <= smooth_d;
            onset_q      <= onset_d;
            release_q    <= release_d;
        end
    end

    assign bus.lock_state    = state_q;
    assign bus.locked        = (state_q == LOCKED) || (state_q == RELEASING);
    assign bus.lock_onset    = onset_q;
    assign bus.lock_release  = release_q;
    assign bus.dwell_count   = dwell_q;
    assign bus.last_dwell    = last_dwell_q;
    assign bus.lock_episodes = episodes_q;
    assign bus.align_smooth  = smooth_q;

endmodule

// File: tb/tb_f2_anchor_lock_tracker.sv
// tb_f2_anchor_lock_tracker
//   Directed scoreboard bench for f2_anchor_lock_tracker. Each sample pushes
//   the outputs it must produce into a queue; after the clock edge the queue
//   is drained and every entry compared against the DUT.
module tb_f2_anchor_lock_tracker;

    localparam int WIDTH = 18;
    localparam int CNT_W = 16;

    localparam int F_STATE   = 0;
    localparam int F_LOCKED  = 1;
    localparam int F_ONSET   = 2;
    localparam int F_RELEASE = 3;
    localparam int F_DWELL   = 4;
    localparam int F_LAST    = 5;
    localparam int F_EPIS    = 6;
    localparam int F_SMOOTH  = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    f2_anchor_lock_tracker_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    f2_anchor_lock_tracker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int check_cnt  = 0;
    int pass_cnt   = 0;
    int sample_cnt = 0;
    int m_smooth   = 0;

    string  tag_q[$];
    int     field_q[$];
    longint val_q[$];

    function automatic longint read_field(input int f);
        case (f)
            F_STATE:   return longint'(bus.lock_state);
            F_LOCKED:  return longint'(bus.locked);
            F_ONSET:   return longint'(bus.lock_onset);
            F_RELEASE: return longint'(bus.lock_release);
            F_DWELL:   return longint'(bus.dwell_count);
            F_LAST:    return longint'(bus.last_dwell);
            F_EPIS:    return longint'(bus.lock_episodes);
            F_SMOOTH:  return longint'($signed(bus.align_smooth));
            default:   return -1;
        endcase
    endfunction

    function automatic int clamp_q14(input int x);
        if (x < 0) return 0;
        if (x > 16384) return 16384;
        return x;
    endfunction

    task automatic check_value(input string tag, input longint got, input longint want);
        check_cnt++;
        if (got == want) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: observed=%0d expected=%0d (sample %0d)", tag, got, want, sample_cnt);
        end
    endtask

    task automatic expect_f(input string tag, input int f, input longint v);
        tag_q.push_back(tag);
        field_q.push_back(f);
        val_q.push_back(v);
    endtask

    task automatic drain();
        string  t;
        int     f;
        longint v;
        while (tag_q.size() > 0) begin
            t = tag_q.pop_front();
            f = field_q.pop_front();
            v = val_q.pop_front();
            check_value(t, read_field(f), v);
        end
    endtask

    task automatic expect_all_zero(input string pfx);
        expect_f({pfx, "_state"},   F_STATE,   0);
        expect_f({pfx, "_locked"},  F_LOCKED,  0);
        expect_f({pfx, "_onset"},   F_ONSET,   0);
        expect_f({pfx, "_release"}, F_RELEASE, 0);
        expect_f({pfx, "_dwell"},   F_DWELL,   0);
        expect_f({pfx, "_last"},    F_LAST,    0);
        expect_f({pfx, "_epis"},    F_EPIS,    0);
        expect_f({pfx, "_smooth"},  F_SMOOTH,  0);
    endtask

    // One clock with the given inputs; the EMA expectation is always queued.
    task automatic sample(input int align, input int det, input bit en, input bit clr);
        logic [31:0] a32;
        logic [31:0] d32;
        a32 = align;
        d32 = det;
        bus.f2_alignment = a32[WIDTH-1:0];
        bus.f2_detuning  = d32[WIDTH-1:0];
        bus.clk_en       = en;
        bus.episodes_clr = clr;
        if (en) m_smooth = m_smooth + ((clamp_q14(align) - m_smooth) >>> 3);
        expect_f("smooth", F_SMOOTH, m_smooth);
        @(posedge clk);
        #1;
        sample_cnt++;
        $display("txn %0d: align=%0d det=%0d en=%0b clr=%0b -> state=%0d onset=%0b rel=%0b dwell=%0d last=%0d epis=%0d smooth=%0d",
                 sample_cnt, align, det, en, clr, bus.lock_state, bus.lock_onset, bus.lock_release,
                 bus.dwell_count, bus.last_dwell, bus.lock_episodes, $signed(bus.align_smooth));
        drain();
    endtask

    // Eight qualifying samples from IDLE: ARMING for seven, LOCKED on the eighth.
    task automatic lock_up();
        for (int i = 1; i <= 8; i++) begin
            if (i < 8) begin
                expect_f("arm_state", F_STATE, 1);
                expect_f("arm_onset", F_ONSET, 0);
            end else begin
                expect_f("lock_state", F_STATE, 2);
                expect_f("lock_onset", F_ONSET, 1);
                expect_f("lock_dwell", F_DWELL, 0);
                expect_f("lock_locked", F_LOCKED, 1);
            end
            sample(16384, 0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        bus.clk_en       = 1'b0;
        bus.f2_alignment = '0;
        bus.f2_detuning  = '0;
        bus.episodes_clr = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        expect_all_zero("reset");
        drain();
        rst = 1'b0;

        // Entry timing and the first EMA steps.
        for (int i = 1; i <= 8; i++) begin
            if (i == 1) expect_f("ema_first", F_SMOOTH, 2048);
            if (i == 2) expect_f("ema_second", F_SMOOTH, 3840);
            if (i < 8) begin
                expect_f("entry_arming", F_STATE, 1);
                expect_f("entry_no_onset", F_ONSET, 0);
            end else begin
                expect_f("entry_locked", F_STATE, 2);
                expect_f("entry_onset", F_ONSET, 1);
            end
            sample(16384, 0, 1'b1, 1'b0);
        end
        // Pulse clears on the next edge even with clk_en low.
        expect_f("onset_clear", F_ONSET, 0);
        expect_f("hold_locked", F_STATE, 2);
        sample(16384, 0, 1'b0, 1'b0);

        // Dwell and normal release: samples 9..32.
        for (int i = 9; i <= 28; i++) begin
            expect_f("dwell_locked", F_STATE, 2);
            if (i == 28) expect_f("dwell_20", F_DWELL, 20);
            sample(16384, 0, 1'b1, 1'b0);
        end
        expect_f("rel_enter", F_STATE, 3);
        expect_f("rel_dwell", F_DWELL, 21);
        sample(0, 0, 1'b1, 1'b0);
        for (int i = 30; i <= 31; i++) begin
            expect_f("rel_hold", F_STATE, 3);
            expect_f("rel_no_pulse", F_RELEASE, 0);
            sample(0, 0, 1'b1, 1'b0);
        end
        expect_f("rel_idle", F_STATE, 0);
        expect_f("rel_pulse", F_RELEASE, 1);
        expect_f("rel_last24", F_LAST, 24);
        expect_f("rel_epis1", F_EPIS, 1);
        expect_f("rel_dwell0", F_DWELL, 0);
        expect_f("rel_unlocked", F_LOCKED, 0);
        sample(0, 0, 1'b1, 1'b0);
        expect_f("rel_pulse_clear", F_RELEASE, 0);
        sample(0, 0, 1'b1, 1'b0);

        // Drop on sample 7 aborts arming.
        for (int i = 1; i <= 7; i++) begin
            if (i < 7) begin
                expect_f("abort_arming", F_STATE, 1);
                sample(16384, 0, 1'b1, 1'b0);
            end else begin
                expect_f("abort_idle", F_STATE, 0);
                expect_f("abort_no_onset", F_ONSET, 0);
                sample(0, 0, 1'b1, 1'b0);
            end
        end

        // Hysteresis band and RELEASING -> LOCKED recovery.
        lock_up();
        for (int i = 1; i <= 50; i++) begin
            expect_f("hyst_locked", F_STATE, 2);
            if (i == 50) expect_f("hyst_dwell50", F_DWELL, 50);
            sample(10000, 0, 1'b1, 1'b0);
        end
        expect_f("hyst_rel1", F_STATE, 3);
        sample(0, 0, 1'b1, 1'b0);
        expect_f("hyst_rel2", F_STATE, 3);
        sample(0, 0, 1'b1, 1'b0);
        expect_f("hyst_relock", F_STATE, 2);
        expect_f("hyst_relock_dwell", F_DWELL, 53);
        sample(8192, 0, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            expect_f("hyst_rel_restart", F_STATE, 3);
            sample(0, 0, 1'b1, 1'b0);
        end
        expect_f("hyst_idle", F_STATE, 0);
        expect_f("hyst_pulse", F_RELEASE, 1);
        expect_f("hyst_last57", F_LAST, 57);
        expect_f("hyst_epis2", F_EPIS, 2);
        sample(0, 0, 1'b1, 1'b0);

        // Veto blocks arming, detuning 16 is harmless, 17 aborts the lock.
        expect_f("veto_no_arm", F_STATE, 0);
        sample(16384, 17, 1'b1, 1'b0);
        lock_up();
        for (int i = 1; i <= 5; i++) begin
            expect_f("det16_locked", F_STATE, 2);
            if (i == 5) expect_f("det16_dwell5", F_DWELL, 5);
            sample(16384, 16, 1'b1, 1'b0);
        end
        expect_f("veto_idle", F_STATE, 0);
        expect_f("veto_pulse", F_RELEASE, 1);
        expect_f("veto_last6", F_LAST, 6);
        expect_f("veto_epis3", F_EPIS, 3);
        sample(16384, 17, 1'b1, 1'b0);

        // Clamp: out-of-range inputs seen through the EMA (veto holds IDLE).
        for (int i = 0; i < 3; i++) begin
            expect_f("clamp_idle", F_STATE, 0);
            sample(-500, 99, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) sample(20000, 99, 1'b1, 1'b0);
        expect_f("clamp_arm", F_STATE, 1);
        sample(20000, 0, 1'b1, 1'b0);
        expect_f("clamp_neg_idle", F_STATE, 0);
        sample(-500, 0, 1'b1, 1'b0);

        // Clear coincident with a release wins.
        lock_up();
        expect_f("clr_idle", F_STATE, 0);
        expect_f("clr_pulse", F_RELEASE, 1);
        expect_f("clr_epis0", F_EPIS, 0);
        expect_f("clr_last1", F_LAST, 1);
        sample(16384, 17, 1'b1, 1'b1);
        lock_up();
        expect_f("post_clr_epis1", F_EPIS, 1);
        sample(16384, 17, 1'b1, 1'b0);

        // clk_en low for 100 cycles freezes everything; clear still acts.
        lock_up();
        for (int i = 1; i <= 3; i++) sample(16384, 0, 1'b1, 1'b0);
        for (int i = 1; i <= 100; i++) begin
            expect_f("freeze_state", F_STATE, 2);
            if (i == 50) expect_f("freeze_clr", F_EPIS, 0);
            if (i == 100) begin
                expect_f("freeze_dwell", F_DWELL, 3);
                expect_f("freeze_locked", F_LOCKED, 1);
                expect_f("freeze_last", F_LAST, 1);
            end
            sample(0, 99, 1'b0, (i == 50));
        end

        // Asynchronous reset mid-LOCKED.
        #2;
        rst = 1'b1;
        #1;
        expect_all_zero("arst");
        drain();
        m_smooth = 0;
        repeat (2) @(posedge clk);
        #1;
        expect_f("arst_no_release", F_RELEASE, 0);
        expect_f("arst_no_onset", F_ONSET, 0);
        drain();
        rst = 1'b0;
        expect_f("post_rst_state", F_STATE, 0);
        expect_f("post_rst_epis", F_EPIS, 0);
        expect_f("post_rst_release", F_RELEASE, 0);
        sample(0, 0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
